// File: rtl/fetch_unit_if.sv
// Control-unit / host-load bus between the fetch stage and its neighbours.
// The master drives PC control and program loading; the fetch unit is the slave.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  pc_enable;
   logic                  pc_load;
   logic                  halt;
   logic                  prog_we;
   logic [ADDR_WIDTH-1:0] prog_addr;
   logic [DATA_WIDTH-1:0] prog_data;
   logic                  prog_start;
   logic [DATA_WIDTH-1:0] instruction;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  running;
   logic                  halted;
   logic                  pc_wrapped;
   logic [7:0]            instr_count;

   modport master (
      output pc_enable, pc_load, halt, prog_we, prog_addr, prog_data, prog_start,
      input  instruction, pc, running, halted, pc_wrapped, instr_count
   );

   modport slave (
      input  pc_enable, pc_load, halt, prog_we, prog_addr, prog_data, prog_start,
      output instruction, pc, running, halted, pc_wrapped, instr_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, register-file program memory with async read, and a
// LOAD/RUN/HALTED sequencer driven by the control unit and a host load port.
module fetch_unit #(
   parameter int                         ADDR_WIDTH = 4,
   parameter int                         DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0]      RESET_FILL = 8'h70
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(8'hF0);

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALTED} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_pc;
   logic                  r_running;
   logic                  r_halted;
   logic                  r_wrapped;
   logic [7:0]            r_cnt;

   logic [DATA_WIDTH-1:0] w_instr;
   logic [7:0]            w_cnt_inc;

   // The decoder sees a NOP while the host is still loading.
   assign w_instr   = (r_state == S_LOAD) ? NOP_WORD : r_mem[r_pc];
   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_LOAD;
         r_pc      <= '0;
         r_running <= 1'b0;
         r_halted  <= 1'b0;
         r_wrapped <= 1'b0;
         r_cnt     <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_FILL;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (bus.prog_we) r_mem[bus.prog_addr] <= bus.prog_data;
               if (bus.prog_start) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
                  r_pc      <= '0;
                  r_wrapped <= 1'b0;
                  r_cnt     <= '0;
               end
            end
            S_RUN: begin
               if (bus.halt) begin
                  r_state   <= S_HALTED;
                  r_running <= 1'b0;
                  r_halted  <= 1'b1;
               end else if (bus.pc_load) begin
                  // Jump target comes from the jump itself; PC has not moved yet.
                  r_pc  <= w_instr[ADDR_WIDTH-1:0];
                  r_cnt <= w_cnt_inc;
               end else if (bus.pc_enable) begin
                  if (r_pc == '1) r_wrapped <= 1'b1;
                  r_pc  <= r_pc + ADDR_WIDTH'(1);
                  r_cnt <= w_cnt_inc;
               end
            end
            S_HALTED: ;
            default: begin
               r_state   <= S_LOAD;
               r_running <= 1'b0;
               r_halted  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instruction = w_instr;
   assign bus.pc          = r_pc;
   assign bus.running     = r_running;
   assign bus.halted      = r_halted;
   assign bus.pc_wrapped  = r_wrapped;
   assign bus.instr_count = r_cnt;
endmodule
